// File: rtl/pipe_out_serializer_pkg.sv
// Shared definitions for the message-to-beat serializer: FSM states,
// header magic and the header word builder.
package pipe_out_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    function automatic logic [31:0] build_header(input logic [7:0]  seq,
                                                 input logic [15:0] len);
        return {HDR_MAGIC, seq, len};
    endfunction

endpackage

// File: rtl/pipe_out_serializer.sv
// Serializes wide messages into a header beat plus payload beats, with a
// one-entry holding register so the next message can start with no bubble.
module pipe_out_serializer
    import pipe_out_serializer_pkg::*;
#(
    parameter int MSG_WIDTH  = 128,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enq__ENA,
    input  logic [MSG_WIDTH-1:0]  enq_v,
    input  logic [15:0]           enq_length,
    output logic                  enq__RDY,
    output logic                  beat_valid,
    output logic [BEAT_WIDTH-1:0] beat_data,
    output logic                  beat_last,
    input  logic                  beat_ready,
    output logic                  err_len
);

    localparam int          MAX_WORDS = MSG_WIDTH / BEAT_WIDTH;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);

    state_e                  state_q, state_d;
    logic                    hold_full_q, hold_full_d;
    logic [MSG_WIDTH-1:0]    hold_v_q, hold_v_d;
    logic [15:0]             hold_len_q, hold_len_d;
    logic [MSG_WIDTH-1:0]    sh_q, sh_d;
    logic [15:0]             rem_q, rem_d;
    logic [7:0]              seq_q, seq_d;
    logic                    err_q, err_d;
    logic                    bv_q, bv_d;
    logic [BEAT_WIDTH-1:0]   bd_q, bd_d;
    logic                    bl_q, bl_d;

    logic                    enq_fire;
    logic                    enq_over;
    logic [15:0]             enq_len_c;
    logic                    hs;
    logic                    start;
    logic                    nxt_ok;
    logic [MSG_WIDTH-1:0]    nxt_v;
    logic [15:0]             nxt_len;

    assign enq__RDY   = ~hold_full_q;
    assign beat_valid = bv_q;
    assign beat_data  = bd_q;
    assign beat_last  = bl_q;
    assign err_len    = err_q;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_v_d    = hold_v_q;
        hold_len_d  = hold_len_q;
        sh_d        = sh_q;
        rem_d       = rem_q;
        seq_d       = seq_q;
        err_d       = err_q;
        bv_d        = bv_q;
        bd_d        = bd_q;
        bl_d        = bl_q;

        enq_fire  = enq__ENA & ~hold_full_q;
        enq_over  = enq_length > MAX_LEN;
        enq_len_c = enq_over ? MAX_LEN : enq_length;
        hs        = bv_q & beat_ready;
        start     = (state_q == IDLE) | (hs & bl_q);

        // A held message always wins; a fresh enq bypasses the holding
        // register only when nothing is waiting in it.
        nxt_ok  = hold_full_q | enq_fire;
        nxt_v   = hold_full_q ? hold_v_q   : enq_v;
        nxt_len = hold_full_q ? hold_len_q : enq_len_c;

        if (enq_fire && enq_over)
            err_d = 1'b1;

        if (start) begin
            if (nxt_ok) begin
                state_d     = HDR;
                hold_full_d = 1'b0;
                sh_d        = nxt_v;
                rem_d       = nxt_len;
                seq_d       = seq_q + 8'd1;
                bv_d        = 1'b1;
                bd_d        = BEAT_WIDTH'(build_header(seq_q, nxt_len));
                bl_d        = (nxt_len == 16'd0);
            end else begin
                state_d = IDLE;
                bv_d    = 1'b0;
                bl_d    = 1'b0;
            end
        end else begin
            if (enq_fire) begin
                hold_full_d = 1'b1;
                hold_v_d    = enq_v;
                hold_len_d  = enq_len_c;
            end
            if (hs) begin
                state_d = BODY;
                bd_d    = sh_q[BEAT_WIDTH-1:0];
                sh_d    = sh_q >> BEAT_WIDTH;
                rem_d   = rem_q - 16'd1;
                bl_d    = (rem_q == 16'd1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_v_q    <= '0;
            hold_len_q  <= '0;
            sh_q        <= '0;
            rem_q       <= '0;
            seq_q       <= '0;
            err_q       <= 1'b0;
            bv_q        <= 1'b0;
            bd_q        <= '0;
            bl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_v_q    <= hold_v_d;
            hold_len_q  <= hold_len_d;
            sh_q        <= sh_d;
            rem_q       <= rem_d;
            seq_q       <= seq_d;
            err_q       <= err_d;
            bv_q        <= bv_d;
            bd_q        <= bd_d;
            bl_q        <= bl_d;
        end
    end

endmodule

// File: doc/pipe_out_serializer.md
PIPE_OUT_SERIALIZER -- requirements
Module: pipe_out_serializer

Interface
REQ-001 The block SHALL have parameter MSG_WIDTH, default 128: width of the message data word accepted per enq.
REQ-002 The block SHALL have parameter BEAT_WIDTH, default 32: width of the host-side beat; MSG_WIDTH SHALL be a multiple of BEAT_WIDTH.
REQ-003 The block SHALL have parameter MAX_WORDS, derived as MSG_WIDTH/BEAT_WIDTH (4 at defaults), not overridable.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high, with ports as follows.
REQ-005 CLK  input  1  sole clock, all state on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 enq__ENA  input  1  message-side enq strobe, legal only while enq__RDY=1.
REQ-008 enq$v  input  MSG_WIDTH  message payload, word 0 in bits [BEAT_WIDTH-1:0].
REQ-009 enq$length  input  16  number of valid BEAT_WIDTH words in enq$v.
REQ-010 enq__RDY  output  1  block can accept a message this cycle.
REQ-011 beat_valid  output  1  beat_data/beat_last valid.
REQ-012 beat_data  output  BEAT_WIDTH  header or payload word.
REQ-013 beat_last  output  1  final beat of the current message.
REQ-014 beat_ready  input  1  host consumer accepts beat when beat_valid & beat_ready.
REQ-015 err_len  output  1  sticky flag: a message arrived with enq$length > MAX_WORDS.

Function
REQ-016 The block SHALL serialize each accepted message as one header beat followed by min(length, MAX_WORDS) payload beats, word 0 first.
REQ-017 The header beat SHALL be {8'hA5, seq[7:0], length_clamped[15:0]} at BEAT_WIDTH=32; seq starts at 0 and increments by 1 per emitted header, wrapping 255->0.
REQ-018 Lengths > MAX_WORDS SHALL be clamped to MAX_WORDS in the header and payload, and SHALL set err_len until reset.
REQ-019 Length 0 SHALL emit the header only, with beat_last=1 on the header.
REQ-020 A one-entry holding register SHALL buffer one message behind the one being serialized; enq__RDY = holding register empty, independent of beat_ready (no combinational path beat_ready->enq__RDY).
REQ-021 State machine: IDLE (beat_valid=0), HDR (header driven), BODY (payload word k driven); IDLE->HDR when the holding register is loaded; HDR->BODY on header handshake if length>0, else ->HDR/IDLE as for last beat; BODY k->k+1 on handshake; on last-beat handshake ->HDR if holding register full, else IDLE.
REQ-022 Latency: enq in cycle N while IDLE SHALL produce header beat_valid=1 in cycle N+1.
REQ-023 Back-to-back messages SHALL incur zero idle cycles between last beat of one and header of the next when the next is already held.
REQ-024 While beat_valid=1 and beat_ready=0, beat_data, beat_last and beat_valid SHALL hold stable.
REQ-025 enq__ENA while enq__RDY=0 SHALL be ignored (no state change); an enq in the same cycle a held message moves into serialization SHALL be ignored because enq__RDY was 0 that cycle.

Reset
REQ-026 With RST=1 at a clock edge: state=IDLE, holding register empty, seq=0, err_len=0, beat_valid=0, beat_last=0, beat_data=0, enq__RDY=1 the following cycle.
REQ-027 Reset mid-message SHALL discard the in-flight and held messages with no further beats emitted.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/HDR/BODY), the header magic 8'hA5, and the header-build function.
REQ-029 No sub-module is needed; holding register, shift register and FSM are inline.

Verification
REQ-030 Single msg: length=4, v=128'h4444_3333_2222_1111_... words, beat_ready=1 -> beats A5000004, 1111, 2222, 3333(…), 4444 with beat_last on 5th, header at N+1.
REQ-031 Backpressure: length=2, beat_ready toggled 0/1 each cycle -> each beat held stable while not ready; exactly 3 beats delivered.
REQ-032 Back-to-back: three length=1 messages enqueued as fast as enq__RDY allows -> headers seq 0,1,2, no idle cycle between messages, enq__RDY=0 while holding register full.
REQ-033 Boundary: length=0 -> single beat A5xx0000 with beat_last=1; length=9 -> header length 4, 4 payload beats, err_len=1 and stays 1.
REQ-034 Wrap and reset: 257 messages -> 257th header seq=0; RST asserted during BODY of a message -> beat_valid=0 next cycle, next message header seq=0, err_len=0.
